// File: rtl/dwb_pkg.sv
// Shared encodings for the data-memory / writeback stage: load/store
// funct3 codes, writeback select, FSM states and decode helpers.
package dwb_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    WB_PC   = 2'b00,
    WB_ALU  = 2'b01,
    WB_LOAD = 2'b10,
    WB_ZERO = 2'b11
  } wb_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Control fields of an accepted memory request, held while BUSY.
  typedef struct packed {
    wb_sel_e    wb_sel;
    logic [2:0] funct3;
    logic       is_load;
    logic       is_store;
    logic [4:0] rd;
    logic       reg_w;
  } req_ctrl_t;

  // Width codes this stage can execute.
  function automatic logic f3_supported(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0] == 1'b0;
      2'b10:   return lo == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised data memory: byte-enabled synchronous write, read data
// delivered through a MEM_LAT-deep register pipeline.
module dmem_bank #(
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-3:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-3:0] raddr,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  logic [31:0] mem  [DEPTH];
  logic [31:0] pipe [MEM_LAT];

  // Byte-lane write; lanes with be low keep their old contents.
  // NOTE: the array has no reset branch on purpose -- contents survive rstN
  // and a reset port on a RAM would prevent block-RAM mapping.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read pipeline: word sampled at the request edge, shifted MEM_LAT-1 more times.
  // NOTE: clocked state always uses <= so every stage sees pre-edge values.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= mem[raddr];
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rdata = pipe[MEM_LAT-1];

endmodule

// File: rtl/dmem_wb_stage.sv
// Data-memory and writeback stage: accepts one request per handshake,
// executes loads/stores against dmem_bank with MEM_LAT latency, traps
// misaligned or malformed accesses and registers the writeback result.
module dmem_wb_stage #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            inValid,
  output logic            inReady,
  input  logic [1:0]      wbCtrl,
  input  logic            memR,
  input  logic            memW,
  input  logic [2:0]      memCtrl,
  input  logic [4:0]      rd,
  input  logic            regW,
  input  logic [XLEN-1:0] pcN,
  input  logic [XLEN-1:0] aluOut,
  input  logic [XLEN-1:0] dataIn,
  output logic            outValid,
  output logic [XLEN-1:0] wbOut,
  output logic [4:0]      wbRd,
  output logic            wbRegW,
  output logic            misalign
);

  import dwb_pkg::*;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            run_q;
  req_ctrl_t       ctrl_q, ctrl_d;
  logic [XLEN-1:0] pc_q, pc_d, alu_q, alu_d, data_q, data_d;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] wb_out_q, wb_out_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_reg_w_q, wb_reg_w_d;
  logic            misalign_q, misalign_d;

  logic            accept, is_mem, bad_op, mem_we;
  logic [3:0]      be;
  logic [31:0]     wdata, rdata;
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;
  logic [XLEN-1:0] load_ext;

  function automatic logic [XLEN-1:0] wb_mux(input wb_sel_e sel, input logic [XLEN-1:0] pc,
                                             input logic [XLEN-1:0] alu, input logic [XLEN-1:0] ld);
    case (sel)
      WB_PC:   return pc;
      WB_ALU:  return alu;
      WB_LOAD: return ld;
      default: return '0;
    endcase
  endfunction

  assign inReady = run_q && (state_q == IDLE);
  assign accept  = inValid && inReady;
  assign is_mem  = memR || memW;
  assign bad_op  = is_mem && ((memR && memW) || !f3_supported(memCtrl) ||
                              !f3_aligned(memCtrl, aluOut[1:0]));

  dmem_bank #(
    .ADDR_W  (ADDR_W),
    .MEM_LAT (MEM_LAT)
  ) u_bank (
    .clk   (clk),
    .rstN  (rstN),
    .we    (mem_we),
    .be    (be),
    .waddr (alu_q[ADDR_W-1:2]),
    .wdata (wdata),
    .raddr (aluOut[ADDR_W-1:2]),
    .rdata (rdata)
  );

  // Store lane steering from the captured width code and address offset.
  always_comb begin
    be    = 4'b1111;
    wdata = data_q[31:0];
    case (ctrl_q.funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << alu_q[1:0];
        wdata = {4{data_q[7:0]}};
      end
      2'b01: begin
        be    = alu_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection and sign/zero extension to XLEN.
  always_comb begin
    lane_byte = rdata[{alu_q[1:0], 3'b000} +: 8];
    lane_half = alu_q[1] ? rdata[31:16] : rdata[15:0];
    load_ext  = '0;
    if (ctrl_q.is_load) begin
      case (ctrl_q.funct3)
        F3_B:    load_ext = XLEN'($signed(lane_byte));
        F3_BU:   load_ext = XLEN'(lane_byte);
        F3_H:    load_ext = XLEN'($signed(lane_half));
        F3_HU:   load_ext = XLEN'(lane_half);
        default: load_ext = XLEN'($signed(rdata));
      endcase
    end
  end

  // Next-state, capture and writeback-result logic.
  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    pc_d        = pc_q;
    alu_d       = alu_q;
    data_d      = data_q;
    out_valid_d = 1'b0;
    wb_out_d    = wb_out_q;
    wb_rd_d     = wb_rd_q;
    wb_reg_w_d  = wb_reg_w_q;
    misalign_d  = misalign_q;
    mem_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            out_valid_d = 1'b1;
            wb_out_d    = wb_mux(wb_sel_e'(wbCtrl), pcN, aluOut, '0);
            wb_rd_d     = rd;
            wb_reg_w_d  = regW;
            misalign_d  = 1'b0;
          end else if (bad_op) begin
            out_valid_d = 1'b1;
            wb_out_d    = aluOut;
            wb_rd_d     = rd;
            wb_reg_w_d  = 1'b0;
            misalign_d  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 2'(MEM_LAT - 1);
            ctrl_d  = '{wb_sel: wb_sel_e'(wbCtrl), funct3: memCtrl, is_load: memR,
                        is_store: memW, rd: rd, reg_w: regW};
            pc_d    = pcN;
            alu_d   = aluOut;
            data_d  = dataIn;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 2'd0) begin
          state_d     = IDLE;
          mem_we      = ctrl_q.is_store;
          out_valid_d = 1'b1;
          wb_out_d    = wb_mux(ctrl_q.wb_sel, pc_q, alu_q, load_ext);
          wb_rd_d     = ctrl_q.rd;
          wb_reg_w_d  = ctrl_q.reg_w;
          misalign_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured request and registered writeback outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      run_q       <= 1'b0;
      ctrl_q      <= '0;
      pc_q        <= '0;
      alu_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      wb_out_q    <= '0;
      wb_rd_q     <= '0;
      wb_reg_w_q  <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_q       <= 1'b1;
      ctrl_q      <= ctrl_d;
      pc_q        <= pc_d;
      alu_q       <= alu_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      wb_out_q    <= wb_out_d;
      wb_rd_q     <= wb_rd_d;
      wb_reg_w_q  <= wb_reg_w_d;
      misalign_q  <= misalign_d;
    end
  end

  assign outValid = out_valid_q;
  assign wbOut    = wb_out_q;
  assign wbRd     = wb_rd_q;
  assign wbRegW   = wb_reg_w_q;
  assign misalign = misalign_q;

endmodule

// File: doc/dmem_wb_stage.md
DMEM_WB_STAGE -- requirements
Module: dmem_wb_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits.
REQ-002 Parameter ADDR_W, default 12, byte-address bits decoded; depth = 2^ADDR_W/4 words.
REQ-003 Parameter MEM_LAT, default 1, legal 1..4, cycles from acceptance to memory data/commit.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rstN  in  1  reset, asynchronous assert, active-low.
REQ-006 inValid  in  1 / inReady  out  1  upstream handshake; transfer when both high at a clk edge.
REQ-007 wbCtrl  in  2  writeback select: 00 pcN, 01 aluOut, 10 load data, 11 zero.
REQ-008 memR  in  1 / memW  in  1  load / store request.
REQ-009 memCtrl  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 rd  in  5 / regW  in  1  destination register and write enable.
REQ-011 pcN, aluOut, dataIn  in  XLEN  return address, effective address/ALU result, store data.
REQ-012 outValid  out  1  one-cycle pulse, writeback result valid.
REQ-013 wbOut  out  XLEN / wbRd  out  5 / wbRegW  out  1  registered writeback result.
REQ-014 misalign  out  1  trap flag, valid only with outValid.

Function
REQ-015 FSM states IDLE and BUSY; inReady SHALL be 1 in IDLE, 0 in BUSY.
REQ-016 IDLE, accepted transfer with memR=memW=0: outputs registered next edge, outValid high one cycle later, state stays IDLE (1/cycle throughput).
REQ-017 IDLE, accepted legal aligned memory op: capture all inputs, enter BUSY, down-counter loaded MEM_LAT-1.
REQ-018 BUSY: counter decrements each cycle; at zero, load data is extended/store committed, outputs registered, state returns to IDLE; outValid asserted MEM_LAT+1 cycles after acceptance.
REQ-019 Store SHALL write memory exactly once, byte-enabled: SB lane addr[1:0], SH lanes addr[1]*2..+1, SW all four; unselected bytes unchanged.
REQ-020 Load SHALL select byte/half by addr[1:0]/addr[1]; B/H sign-extend, BU/HU zero-extend to XLEN.
REQ-021 Alignment: H/HU require addr[0]=0, W requires addr[1:0]=0.
REQ-022 Misaligned access, unsupported memCtrl (011,110,111) with memory op, or memR&memW both set: no memory access, outValid next cycle, misalign=1, wbRegW forced 0, wbOut=aluOut.
REQ-023 Address bits above ADDR_W-1 SHALL be ignored (wrap-around).
REQ-024 inValid while BUSY SHALL be ignored; upstream holds inputs until inReady.
REQ-025 Cycle outValid pulses SHALL be IDLE, so a new transfer may be accepted that same edge.
REQ-026 wbRd and wbRegW SHALL pass through from accepted rd/regW except per REQ-022.

Reset
REQ-027 While rstN low: state IDLE, inReady 0, outValid 0, wbOut 0, wbRd 0, wbRegW 0, misalign 0, counter 0.
REQ-028 inReady SHALL rise on the first edge after rstN deasserts.
REQ-029 Reset during BUSY aborts the op; a store not yet committed SHALL NOT write; memory contents not reset.

Structure
REQ-030 Shared package dwb_pkg: memCtrl funct3 localparams, wbCtrl encoding enum, FSM state enum.
REQ-031 One sub-module dmem_bank (param ADDR_W, MEM_LAT): byte-enable synchronous write, read data pipelined to MEM_LAT; all other logic in dmem_wb_stage.

Verification
REQ-032 MEM_LAT=1: SW 0xDEADBEEF @0x010, then LW @0x010 rd=5 -> outValid 2 cycles after accept, wbOut=0xDEADBEEF, wbRd=5, wbRegW=1.
REQ-033 SB 0x80 @0x013, LB @0x013 -> 0xFFFFFF80; LBU -> 0x00000080; word @0x010 = 0x80ADBEEF.
REQ-034 LH @0x011 -> next-cycle outValid, misalign=1, wbRegW=0, memory unchanged; SW @0x012 likewise no write.
REQ-035 MEM_LAT=3: inValid held high across LW @0x020 then ALU op (wbCtrl=01, aluOut=7) -> inReady low 3 cycles, load result at accept+4, ALU result next cycle wbOut=7; wbCtrl=00 returns pcN.
REQ-036 MEM_LAT=3: SW 0x12345678 @0x030 accepted, rstN pulsed low next cycle -> all outputs 0, later LW @0x030 returns prior contents.
REQ-037 ADDR_W=12: SW 0xA5A5A5A5 @0x1004, LW @0x0004 -> 0xA5A5A5A5 (wrap).
